// File: rtl/rx_par_pkg.sv
// -----------------------------------------------------------------------------
// rx_par_pkg
// Shared definitions for the UART receive parity engine:
//   - PAR_MODE encodings (even / odd / mark / space)
//   - engine state enumeration
//   - exp_parity(): parity bit the frame must carry for a given mode and the
//     running XOR of its data bits
// -----------------------------------------------------------------------------
package rx_par_pkg;

    localparam logic [1:0] PAR_EVEN  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_MARK  = 2'b10;
    localparam logic [1:0] PAR_SPACE = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_e;

    // acc is the XOR of all data bits received so far in the frame.
    function automatic logic exp_parity(input logic [1:0] mode, input logic acc);
        logic p;
        case (mode)
            PAR_EVEN:  p = acc;
            PAR_ODD:   p = ~acc;
            PAR_MARK:  p = 1'b1;
            default:   p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/rx_parity_engine_if.sv
// -----------------------------------------------------------------------------
// rx_parity_engine_if
// Bundle between the RX data sampler / RX FSM and the parity engine.
//   Configuration : PAR_EN, PAR_MODE (latched by the engine at frame_start)
//   Sample stream : frame_start, sample_valid, sampled_bit
//   Error control : err_clr
//   Results       : P_DATA, par_done, par_err, par_err_sticky, err_count
// modport slave  : the parity engine
// modport master : whatever drives frames into it and consumes the results
// -----------------------------------------------------------------------------
interface rx_parity_engine_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 8
);
    logic                     PAR_EN;
    logic [1:0]               PAR_MODE;
    logic                     frame_start;
    logic                     sample_valid;
    logic                     sampled_bit;
    logic                     err_clr;
    logic [DATA_WIDTH-1:0]    P_DATA;
    logic                     par_done;
    logic                     par_err;
    logic                     par_err_sticky;
    logic [ERR_CNT_WIDTH-1:0] err_count;

    modport slave (
        input  PAR_EN, PAR_MODE, frame_start, sample_valid, sampled_bit, err_clr,
        output P_DATA, par_done, par_err, par_err_sticky, err_count
    );

    modport master (
        output PAR_EN, PAR_MODE, frame_start, sample_valid, sampled_bit, err_clr,
        input  P_DATA, par_done, par_err, par_err_sticky, err_count
    );
endinterface

// File: rtl/rx_parity_engine.sv
// -----------------------------------------------------------------------------
// rx_parity_engine
// Serial parity engine for the UART receive path. Deserialises DATA_WIDTH
// data bits (LSB first), accumulates their parity bit by bit, checks the
// optional parity bit against even/odd/mark/space and reports the result.
//
// Ports
//   CLK  : receiver clock
//   RST  : asynchronous active-low reset
//   bus  : rx_parity_engine_if.slave
//            in : PAR_EN, PAR_MODE, frame_start, sample_valid, sampled_bit,
//                 err_clr
//            out: P_DATA (held until next completion), par_done (pulse),
//                 par_err (pulse with par_done), par_err_sticky,
//                 err_count (saturating)
// All outputs are registered.
// -----------------------------------------------------------------------------
module rx_parity_engine
    import rx_par_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                CLK,
    input  logic                RST,
    rx_parity_engine_if.slave   bus
);

    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    state_e                   state_q,  state_d;
    logic                     en_q,     en_d;
    logic [1:0]               mode_q,   mode_d;
    logic                     acc_q,    acc_d;
    logic [IDX_W-1:0]         idx_q,    idx_d;
    logic [DATA_WIDTH-1:0]    shift_q,  shift_d;
    logic [DATA_WIDTH-1:0]    data_q,   data_d;
    logic                     done_q,   done_d;
    logic                     err_q,    err_d;
    logic                     sticky_q, sticky_d;
    logic [ERR_CNT_WIDTH-1:0] cnt_q,    cnt_d;
    logic [ERR_CNT_WIDTH-1:0] cnt_base;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            en_q     <= 1'b0;
            mode_q   <= '0;
            acc_q    <= 1'b0;
            idx_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            done_q   <= done_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        mode_d   = mode_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        data_d   = data_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        cnt_base = '0;
        cnt_d    = '0;
        sticky_d = 1'b0;

        // frame_start wins in every state: it aborts any frame in flight
        // silently and drops a sample_valid arriving in the same cycle.
        if (bus.frame_start) begin
            state_d = DATA;
            en_d    = bus.PAR_EN;
            mode_d  = bus.PAR_MODE;
            acc_d   = 1'b0;
            idx_d   = '0;
        end else begin
            case (state_q)
                DATA: begin
                    if (bus.sample_valid) begin
                        acc_d          = acc_q ^ bus.sampled_bit;
                        shift_d[idx_q] = bus.sampled_bit;
                        idx_d          = idx_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            if (en_q) begin
                                state_d = PARITY;
                            end else begin
                                // No parity bit: the frame completes on the
                                // last data bit, which must be in P_DATA.
                                state_d = IDLE;
                                done_d  = 1'b1;
                                data_d  = shift_d;
                            end
                        end
                    end
                end
                PARITY: begin
                    if (bus.sample_valid) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        data_d  = shift_q;
                        err_d   = (bus.sampled_bit != exp_parity(mode_q, acc_q));
                    end
                end
                default: ;
            endcase
        end

        // Clear is applied before a coincident error, so clear+error leaves
        // the counter at one and the sticky flag set.
        cnt_base = bus.err_clr ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (err_d && !(&cnt_base)) begin
            cnt_d = cnt_base + 1'b1;
        end
        sticky_d = (sticky_q & ~bus.err_clr) | err_d;
    end

    assign bus.P_DATA         = data_q;
    assign bus.par_done       = done_q;
    assign bus.par_err        = err_q;
    assign bus.par_err_sticky = sticky_q;
    assign bus.err_count      = cnt_q;

endmodule

// File: tb/tb_rx_parity_engine.sv
// -----------------------------------------------------------------------------
// tb_rx_parity_engine
// Two engines share one stimulus stream: A (8 data bits, 8-bit counter) and
// B (7 data bits, 2-bit counter). A frame-level model predicts each engine's
// outputs; directed literal checks pin the model on hand-computed frames.
// -----------------------------------------------------------------------------
module tb_rx_parity_engine;
    import rx_par_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       par_en = 1'b0;
    logic [1:0] par_mode = 2'b00;
    logic       fs = 1'b0;
    logic       sv = 1'b0;
    logic       sbit = 1'b0;
    logic       clr = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    rx_parity_engine_if #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(8)) ifA ();
    rx_parity_engine_if #(.DATA_WIDTH(7), .ERR_CNT_WIDTH(2)) ifB ();

    assign ifA.PAR_EN       = par_en;
    assign ifA.PAR_MODE     = par_mode;
    assign ifA.frame_start  = fs;
    assign ifA.sample_valid = sv;
    assign ifA.sampled_bit  = sbit;
    assign ifA.err_clr      = clr;
    assign ifB.PAR_EN       = par_en;
    assign ifB.PAR_MODE     = par_mode;
    assign ifB.frame_start  = fs;
    assign ifB.sample_valid = sv;
    assign ifB.sampled_bit  = sbit;
    assign ifB.err_clr      = clr;

    rx_parity_engine #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(8)) dutA (
        .CLK (clk),
        .RST (rst_n),
        .bus (ifA)
    );

    rx_parity_engine #(.DATA_WIDTH(7), .ERR_CNT_WIDTH(2)) dutB (
        .CLK (clk),
        .RST (rst_n),
        .bus (ifB)
    );

    // ---------------- frame-level model ----------------
    typedef struct {
        logic        act;
        logic        en;
        logic [1:0]  mode;
        int          nb;
        logic [15:0] word;
        logic        done;
        logic        err;
        logic        sticky;
        int          cnt;
        logic [15:0] data;
    } mstate_t;

    function automatic mstate_t mreset();
        mstate_t r;
        r.act = 0; r.en = 0; r.mode = 0; r.nb = 0; r.word = 0;
        r.done = 0; r.err = 0; r.sticky = 0; r.cnt = 0; r.data = 0;
        return r;
    endfunction

    function automatic mstate_t mstep(mstate_t s, int w, int cmax, logic f, logic en,
                                      logic [1:0] mode, logic v, logic b, logic c);
        mstate_t n = s;
        logic expb;
        n.done = 0;
        n.err  = 0;
        if (c) begin
            n.sticky = 0;
            n.cnt    = 0;
        end
        if (f) begin
            n.act = 1; n.en = en; n.mode = mode; n.nb = 0; n.word = 0;
        end else if (s.act && v) begin
            if (s.nb < w) begin
                n.word[s.nb] = b;
                n.nb = s.nb + 1;
                if (n.nb == w && !s.en) begin
                    n.act = 0; n.done = 1; n.data = n.word;
                end
            end else begin
                case (s.mode)
                    2'b00:   expb = ^s.word;
                    2'b01:   expb = ~(^s.word);
                    2'b10:   expb = 1'b1;
                    default: expb = 1'b0;
                endcase
                n.act = 0; n.done = 1; n.data = s.word;
                if (b != expb) begin
                    n.err = 1;
                    n.sticky = 1;
                    n.cnt = (n.cnt < cmax) ? n.cnt + 1 : cmax;
                end
            end
        end
        return n;
    endfunction

    mstate_t mA, mB;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mA <= mreset();
            mB <= mreset();
        end else begin
            mA <= mstep(mA, 8, 255, fs, par_en, par_mode, sv, sbit, clr);
            mB <= mstep(mB, 7, 3,   fs, par_en, par_mode, sv, sbit, clr);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        chk("A.par_done", 32'(ifA.par_done),       32'(mA.done));
        chk("A.par_err",  32'(ifA.par_err),        32'(mA.err));
        chk("A.sticky",   32'(ifA.par_err_sticky), 32'(mA.sticky));
        chk("A.count",    32'(ifA.err_count),      32'(mA.cnt));
        chk("A.P_DATA",   32'(ifA.P_DATA),         32'(mA.data[7:0]));
        chk("B.par_done", 32'(ifB.par_done),       32'(mB.done));
        chk("B.par_err",  32'(ifB.par_err),        32'(mB.err));
        chk("B.sticky",   32'(ifB.par_err_sticky), 32'(mB.sticky));
        chk("B.count",    32'(ifB.err_count),      32'(mB.cnt));
        chk("B.P_DATA",   32'(ifB.P_DATA),         32'(mB.data[6:0]));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic en, input logic [1:0] mode);
        fs = 1'b1; sv = 1'b0; par_en = en; par_mode = mode;
        step();
        fs = 1'b0;
    endtask

    // d[n-1:0] are sent LSB first, one per sample; gap idle cycles between
    // samples; tog flips PAR_MODE mid-frame; clr_last raises err_clr with the
    // final sample.
    task automatic bits(input logic [8:0] d, input int n, input int gap,
                        input bit tog, input bit clr_last);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    sv = 1'b0;
                    step();
                end
            end
            if (tog && i == 3) par_mode = par_mode ^ 2'b01;
            sv = 1'b1;
            sbit = d[i];
            clr = (clr_last && i == n - 1);
            step();
        end
        sv = 1'b0;
        clr = 1'b0;
    endtask

    task automatic chk_zero_all();
        chk("rst A.done",  32'(ifA.par_done),       32'd0);
        chk("rst A.data",  32'(ifA.P_DATA),         32'd0);
        chk("rst A.stk",   32'(ifA.par_err_sticky), 32'd0);
        chk("rst A.cnt",   32'(ifA.err_count),      32'd0);
        chk("rst B.err",   32'(ifB.par_err),        32'd0);
        chk("rst B.cnt",   32'(ifB.err_count),      32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) step();
        chk_zero_all();
        rst_n = 1'b1;
        step();

        // Even, 0xA5 (four ones), parity 0: clean frame on A.
        start(1'b1, PAR_EVEN);
        bits({1'b0, 8'hA5}, 9, 0, 1'b0, 1'b0);
        chk("even A5 done", 32'(ifA.par_done),  32'd1);
        chk("even A5 data", 32'(ifA.P_DATA),    32'hA5);
        chk("even A5 err",  32'(ifA.par_err),   32'd0);
        chk("even A5 cnt",  32'(ifA.err_count), 32'd0);

        // Odd, 0x01 (one one), parity 1: expected 0, so an error; back-to-back start.
        start(1'b1, PAR_ODD);
        bits({1'b1, 8'h01}, 9, 1, 1'b0, 1'b0);
        chk("odd err",    32'(ifA.par_err),        32'd1);
        chk("odd sticky", 32'(ifA.par_err_sticky), 32'd1);
        chk("odd cnt",    32'(ifA.err_count),      32'd1);
        step();
        chk("sticky held", 32'(ifA.par_err_sticky), 32'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr sticky", 32'(ifA.par_err_sticky), 32'd0);
        chk("clr cnt",    32'(ifA.err_count),      32'd0);

        // Parity disabled, 7-bit 0x55 on B; a later extra sample is ignored.
        start(1'b0, PAR_EVEN);
        bits(9'h055, 7, 0, 1'b0, 1'b0);
        chk("nopar B done", 32'(ifB.par_done), 32'd1);
        chk("nopar B data", 32'(ifB.P_DATA),   32'h55);
        chk("nopar B err",  32'(ifB.par_err),  32'd0);
        sv = 1'b1; sbit = 1'b1;
        step();
        sv = 1'b0;
        chk("nopar B extra", 32'(ifB.par_done), 32'd0);
        step();

        // Mark with parity 0 -> error.
        start(1'b1, PAR_MARK);
        bits({1'b0, 8'h00}, 9, 0, 1'b0, 1'b0);
        chk("mark err", 32'(ifA.par_err), 32'd1);
        // Space with parity 0 -> no error.
        start(1'b1, PAR_SPACE);
        bits({1'b0, 8'hFF}, 9, 0, 1'b0, 1'b0);
        chk("space err", 32'(ifA.par_err), 32'd0);
        // Even 0x03 parity 0, PAR_MODE flipped to odd mid-frame -> still clean.
        start(1'b1, PAR_EVEN);
        bits({1'b0, 8'h03}, 9, 0, 1'b1, 1'b0);
        chk("toggle err",  32'(ifA.par_err),  32'd0);
        chk("toggle done", 32'(ifA.par_done), 32'd1);

        // Abort after 4 data bits, then a full 0x3C even frame with spacing.
        start(1'b1, PAR_ODD);
        bits(9'h00F, 4, 0, 1'b0, 1'b0);
        start(1'b1, PAR_EVEN);
        chk("abort done", 32'(ifA.par_done), 32'd0);
        bits({1'b0, 8'h3C}, 9, 2, 1'b0, 1'b0);
        chk("3C done", 32'(ifA.par_done), 32'd1);
        chk("3C data", 32'(ifA.P_DATA),   32'h3C);
        chk("3C err",  32'(ifA.par_err),  32'd0);

        // Reset in the middle of a frame.
        start(1'b1, PAR_EVEN);
        bits(9'h007, 3, 0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_zero_all();
        step();
        rst_n = 1'b1;
        step();

        // B saturation: 7-bit 0x01 even needs parity 1; send 0.
        for (int k = 0; k < 4; k++) begin
            start(1'b1, PAR_EVEN);
            bits(9'h001, 8, 0, 1'b0, 1'b0);
            chk("sat B err", 32'(ifB.par_err), 32'd1);
            chk("sat B cnt", 32'(ifB.err_count), (k < 3) ? 32'(k + 1) : 32'd3);
        end
        start(1'b1, PAR_EVEN);
        bits(9'h001, 8, 0, 1'b0, 1'b1);
        chk("sat clr cnt",    32'(ifB.err_count),      32'd1);
        chk("sat clr sticky", 32'(ifB.par_err_sticky), 32'd1);

        repeat (3) step();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
